// File: rtl/shift_sequencer.sv
// Shift sequencer: drives single-bit shift strobes into an external register.
// Optional abort port is compiled in with SHIFT_SEQUENCER_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one strobe per cycle, counter counts down the remaining steps
// DONE  | one-cycle completion pulse, start may be accepted again here
module shift_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [AMT_WIDTH-1:0] amount,
`ifdef SHIFT_SEQUENCER_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 reg_msb,
  output logic                 sr,
  output logic                 ir,
  output logic                 sl,
  output logic                 il,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_SHL, OP_SHR, OP_SAR, OP_ROL} op_e;

  if (DATA_WIDTH < 1 || AMT_WIDTH < 1) begin : g_param_check
    $error("shift_sequencer: DATA_WIDTH and AMT_WIDTH must be positive");
  end

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [AMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sr_q, sr_d, sl_q, sl_d;
  logic                 abort_req;

`ifdef SHIFT_SEQUENCER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sr_d    = 1'b0;
    sl_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d = op_e'(op);
          if (amount == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
            cnt_d   = amount;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (abort_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= AMT_WIDTH'(1)) begin
          // last step: counter lands on 0 and never wraps
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // strobes are registered so they line up with the SHIFT cycles
    if (state_d == SHIFT) begin
      sl_d = (op_d == OP_SHL) || (op_d == OP_ROL);
      sr_d = !sl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_SHL;
      cnt_q   <= '0;
      sr_q    <= 1'b0;
      sl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      sl_q    <= sl_d;
    end
  end

  assign sr   = sr_q;
  assign sl   = sl_q;
  assign ir   = sr_q && (op_q == OP_SAR) && reg_msb;
  assign il   = sl_q && (op_q == OP_ROL) && reg_msb;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 16-bit shift register.
// Builds with or without SHIFT_SEQUENCER_ABORT_EN.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  amount = 4'd0;
  logic        abort = 1'b0;
  logic        sr, ir, sl, il, busy, done;
  logic [15:0] regv = 16'h0000;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;

  int checks = 0;
  int errors = 0;
  int n_sr, n_sl, n_done, n_busy;

  always #5 clk = ~clk;

  shift_sequencer #(.DATA_WIDTH(16), .AMT_WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .amount  (amount),
`ifdef SHIFT_SEQUENCER_ABORT_EN
    .abort   (abort),
`endif
    .reg_msb (regv[15]),
    .sr      (sr),
    .ir      (ir),
    .sl      (sl),
    .il      (il),
    .busy    (busy),
    .done    (done)
  );

  // register driven by the strobes
  always @(posedge clk) begin
    if (load)    regv <= load_val;
    else if (sl) regv <= {regv[14:0], il};
    else if (sr) regv <= {ir, regv[15:1]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_outs"}, {28'd0, sr, sl, ir, il}, 32'd0);
    chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic load_reg(input logic [15:0] v);
    @(negedge clk); load = 1'b1; load_val = v;
    @(negedge clk); load = 1'b0;
  endtask

  // start at the next edge, check each SHIFT cycle and the DONE cycle
  task automatic do_op(input string tag, input logic [1:0] o, input logic [3:0] a,
                       input logic exp_in);
    logic left;
    left = (o == 2'b00) || (o == 2'b11);
    @(negedge clk); start = 1'b1; op = o; amount = a;
    for (int k = 1; k <= int'(a); k++) begin
      @(negedge clk); start = 1'b0;
      chk({tag, "_strobe"}, {30'd0, sl, sr}, {30'd0, left, !left});
      chk({tag, "_serial"}, {30'd0, il, ir}, left ? {30'd0, exp_in, 1'b0} : {30'd0, 1'b0, exp_in});
      chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd2);
    end
    @(negedge clk); start = 1'b0;
    chk({tag, "_done"}, {28'd0, busy, done, sr, sl}, 32'd4);
  endtask

  initial begin
    // reset
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    // SHL 3 from 0x8001
    load_reg(16'h8001);
    do_op("shl3", 2'b00, 4'd3, 1'b0);
    chk("shl3_reg", {16'd0, regv}, 32'h0008);
    @(negedge clk);
    chk_idle("shl3_idle");

    // SAR 4 from 0x8000: sign fills in
    load_reg(16'h8000);
    do_op("sar4", 2'b10, 4'd4, 1'b1);
    chk("sar4_reg", {16'd0, regv}, 32'hF800);

    // ROL 1 from 0x8001
    load_reg(16'h8001);
    do_op("rol1", 2'b11, 4'd1, 1'b1);
    chk("rol1_reg", {16'd0, regv}, 32'h0003);

    // amount 0 for every op: straight to DONE, register untouched
    for (int o = 0; o < 4; o++) begin
      do_op("amt0", 2'(o), 4'd0, 1'b0);
      chk("amt0_reg", {16'd0, regv}, 32'h0003);
      @(negedge clk);
      chk_idle("amt0_idle");
    end

    // SHR 5 with start re-asserted in cycle t+2 (SHL 1) which must be ignored
    load_reg(16'hF000);
    @(negedge clk); start = 1'b1; op = 2'b01; amount = 4'd5;
    n_sr = 0; n_sl = 0; n_done = 0; n_busy = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_sr += int'(sr); n_sl += int'(sl); n_done += int'(done); n_busy += int'(busy);
      if (k == 6) chk("shr5_done_cycle", {31'd0, done}, 32'd1);
      if (k == 2) begin start = 1'b1; op = 2'b00; amount = 4'd1; end
      else start = 1'b0;
    end
    chk("shr5_sr_count", n_sr, 5);
    chk("shr5_sl_count", n_sl, 0);
    chk("shr5_busy_count", n_busy, 5);
    chk("shr5_done_count", n_done, 1);
    chk("shr5_reg", {16'd0, regv}, 32'h0780);

    // start accepted during DONE: SHL 1 then SHR 2 back-to-back
    load_reg(16'h0001);
    do_op("b2b_a", 2'b00, 4'd1, 1'b0);
    start = 1'b1; op = 2'b01; amount = 4'd2;
    @(negedge clk); start = 1'b0;
    chk("b2b_sr1", {30'd0, sr, sl}, 32'd2);
    @(negedge clk);
    chk("b2b_sr2", {30'd0, sr, busy}, 32'd3);
    @(negedge clk);
    chk("b2b_done", {30'd0, done, sr}, 32'd2);
    chk("b2b_reg", {16'd0, regv}, 32'h0000);

    // SHL 8 with reset sampled at edge t+4: partial shift kept, no done
    load_reg(16'h8001);
    @(negedge clk); start = 1'b1; op = 2'b00; amount = 4'd8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); start = 1'b0;
      chk("rst_mid_sl", {30'd0, sl, busy}, 32'd3);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_idle("rst_mid_t4");
    chk("rst_mid_reg", {16'd0, regv}, 32'h0008);
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_done += int'(done) + int'(sl) + int'(busy);
    end
    chk("rst_mid_quiet", n_done, 0);

`ifdef SHIFT_SEQUENCER_ABORT_EN
    // same case with abort instead of reset
    load_reg(16'h8001);
    @(negedge clk); start = 1'b1; op = 2'b00; amount = 4'd8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); start = 1'b0;
      chk("abort_mid_sl", {30'd0, sl, busy}, 32'd3);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk_idle("abort_t4");
    chk("abort_reg", {16'd0, regv}, 32'h0008);
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_done += int'(done) + int'(sl) + int'(busy);
    end
    chk("abort_quiet", n_done, 0);
    // abort outside SHIFT has no effect
    abort = 1'b1;
    do_op("abort_idle", 2'b11, 4'd0, 1'b0);
    abort = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
